// File: rtl/adc_capture_sequencer.sv
// Start/settle/run/flush sequencer gating the x400 ADC 2x1 gearbox.
// Single clk1x domain; owns the quasi-static IQ swap setting.
module adc_capture_sequencer #(
  parameter int SETTLE_CYCLES = 16,
  parameter int FLUSH_CYCLES  = 4,
  parameter int CNT_W         = 32
) (
  input  logic             clk1x,
  input  logic             reset_1x,
  input  logic             start_1x,
  input  logic             stop_1x,
  input  logic [CNT_W-1:0] burst_len_1x,
  input  logic             swap_iq_cfg_1x,
  input  logic             valid_in_1x,
  output logic             enable_1x,
  output logic             swap_iq_1x,
  output logic             busy_1x,
  output logic             done_1x,
  output logic             error_1x,
  output logic [CNT_W-1:0] word_count_1x
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES - 1);
  localparam logic [FW-1:0] FLUSH_MAX  = FW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RUN,
    S_FLUSH
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [FW-1:0]    flush_q, flush_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             swap_q, swap_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             en_q, en_d;

  always_ff @(posedge clk1x) begin
    if (reset_1x) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      flush_q  <= '0;
      burst_q  <= '0;
      wcnt_q   <= '0;
      swap_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      flush_q  <= flush_d;
      burst_q  <= burst_d;
      wcnt_q   <= wcnt_d;
      swap_q   <= swap_d;
      err_q    <= err_d;
      done_q   <= done_d;
      en_q     <= en_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    flush_d  = flush_q;
    burst_d  = burst_q;
    wcnt_d   = wcnt_q;
    swap_d   = swap_q;
    err_d    = err_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_1x) begin
          burst_d  = burst_len_1x;
          swap_d   = swap_iq_cfg_1x;
          wcnt_d   = '0;
          err_d    = 1'b0;
          settle_d = '0;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (stop_1x) begin
          flush_d = '0;
          state_d = S_FLUSH;
        end else if (!valid_in_1x) begin
          settle_d = '0;
        end else if (settle_q == SETTLE_MAX) begin
          state_d = S_RUN;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_RUN: begin
        // A coincident stop, last word or valid drop all funnel into one exit.
        if (valid_in_1x) begin
          if (wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;
          if (stop_1x ||
              (burst_q != '0 && wcnt_q == burst_q - 1'b1)) begin
            flush_d = '0;
            state_d = S_FLUSH;
          end
        end else begin
          err_d   = 1'b1;
          flush_d = '0;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (flush_q == FLUSH_MAX) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    en_d = (state_d == S_RUN);
  end

  assign enable_1x     = en_q;
  assign swap_iq_1x    = swap_q;
  assign busy_1x       = (state_q != S_IDLE);
  assign done_1x       = done_q;
  assign error_1x      = err_q;
  assign word_count_1x = wcnt_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench for adc_capture_sequencer with a result scoreboard.
// Expected capture results are queued at start and checked at done.
module tb_adc_capture_sequencer;

  logic        clk1x = 1'b0;
  logic        reset_1x;
  logic        start_1x;
  logic        stop_1x;
  logic [31:0] burst_len_1x;
  logic        swap_iq_cfg_1x;
  logic        valid_in_1x;
  logic        enable_1x;
  logic        swap_iq_1x;
  logic        busy_1x;
  logic        done_1x;
  logic        error_1x;
  logic [31:0] word_count_1x;

  typedef struct packed {
    logic [31:0] wc;
    logic        err;
    logic        swap;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  adc_capture_sequencer #(
    .SETTLE_CYCLES(16),
    .FLUSH_CYCLES (4),
    .CNT_W        (32)
  ) dut (
    .clk1x         (clk1x),
    .reset_1x      (reset_1x),
    .start_1x      (start_1x),
    .stop_1x       (stop_1x),
    .burst_len_1x  (burst_len_1x),
    .swap_iq_cfg_1x(swap_iq_cfg_1x),
    .valid_in_1x   (valid_in_1x),
    .enable_1x     (enable_1x),
    .swap_iq_1x    (swap_iq_1x),
    .busy_1x       (busy_1x),
    .done_1x       (done_1x),
    .error_1x      (error_1x),
    .word_count_1x (word_count_1x)
  );

  always #5 clk1x = ~clk1x;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk1x);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] blen, input logic cfg,
                          input logic [31:0] exp_wc, input logic exp_err);
    exp_t e;
    burst_len_1x   = blen;
    swap_iq_cfg_1x = cfg;
    start_1x       = 1'b1;
    e.wc   = exp_wc;
    e.err  = exp_err;
    e.swap = cfg;
    sb.push_back(e);
    tick();
    start_1x = 1'b0;
  endtask

  // n counts cycles after the start edge; inputs set at n are sampled at n+1's edge.
  task automatic observe(input int budget, input int drop_at,
                         input int stop_at, input int start_at,
                         input bit toggle, input logic exp_swap,
                         output int en_first, output int en_n,
                         output int done_at, output int swap_bad);
    en_first = -1;
    en_n     = 0;
    done_at  = -1;
    swap_bad = 0;
    for (int n = 0; n < budget; n++) begin
      if (swap_iq_1x !== exp_swap) swap_bad++;
      if (enable_1x === 1'b1) begin
        if (en_first < 0) en_first = n;
        en_n++;
      end
      if (done_1x === 1'b1) begin
        done_at = n;
        break;
      end
      valid_in_1x = (n != drop_at);
      stop_1x     = (n == stop_at);
      start_1x    = (n == start_at);
      if (toggle) swap_iq_cfg_1x = ~swap_iq_cfg_1x;
      tick();
    end
    valid_in_1x = 1'b1;
    stop_1x     = 1'b0;
    start_1x    = 1'b0;
  endtask

  task automatic check_done(input string tag, input int done_at,
                            input int exp_done);
    exp_t e;
    chk({tag, "_done_at"}, done_at, exp_done);
    n_cmp++;
    assert (sb.size() > 0) else begin
      n_err++;
      $error("FAIL %s_sb: observed empty expected entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_wc"}, word_count_1x, e.wc);
      chk({tag, "_err"}, {31'd0, error_1x}, {31'd0, e.err});
      chk({tag, "_swap"}, {31'd0, swap_iq_1x}, {31'd0, e.swap});
    end
  endtask

  initial begin
    int ef, en, da, sbad;
    reset_1x       = 1'b1;
    start_1x       = 1'b0;
    stop_1x        = 1'b0;
    burst_len_1x   = '0;
    swap_iq_cfg_1x = 1'b0;
    valid_in_1x    = 1'b0;
    tick();
    tick();
    chk("rst_enable", {31'd0, enable_1x}, 32'd0);
    chk("rst_busy", {31'd0, busy_1x}, 32'd0);
    chk("rst_done", {31'd0, done_1x}, 32'd0);
    chk("rst_error", {31'd0, error_1x}, 32'd0);
    chk("rst_swap", {31'd0, swap_iq_1x}, 32'd0);
    chk("rst_wc", word_count_1x, 32'd0);
    reset_1x    = 1'b0;
    valid_in_1x = 1'b1;
    tick();

    // Plain burst of 8
    do_start(32'd8, 1'b0, 32'd8, 1'b0);
    chk("t1_busy", {31'd0, busy_1x}, 32'd1);
    observe(200, -1, -1, -1, 1'b0, 1'b0, ef, en, da, sbad);
    chk("t1_en_first", ef, 32'd16);
    chk("t1_en_len", en, 32'd8);
    check_done("t1", da, 28);
    tick();
    chk("t1_done_pulse", {31'd0, done_1x}, 32'd0);
    chk("t1_wc_hold", word_count_1x, 32'd8);

    // Settle restart on one dropped valid
    do_start(32'd8, 1'b0, 32'd8, 1'b0);
    observe(200, 9, -1, -1, 1'b0, 1'b0, ef, en, da, sbad);
    chk("t2_en_first", ef, 32'd26);
    chk("t2_en_len", en, 32'd8);
    check_done("t2", da, 38);
    tick();

    // Valid loss mid-run
    do_start(32'd100, 1'b0, 32'd5, 1'b1);
    observe(300, 21, -1, -1, 1'b0, 1'b0, ef, en, da, sbad);
    chk("t3_en_first", ef, 32'd16);
    chk("t3_en_len", en, 32'd6);
    check_done("t3", da, 26);
    tick();
    chk("t3_err_sticky", {31'd0, error_1x}, 32'd1);

    // Continuous capture with stop; start during flush ignored
    do_start(32'd0, 1'b0, 32'd40, 1'b0);
    chk("t4_err_clr", {31'd0, error_1x}, 32'd0);
    observe(300, -1, 55, 57, 1'b0, 1'b0, ef, en, da, sbad);
    chk("t4_en_first", ef, 32'd16);
    chk("t4_en_len", en, 32'd40);
    check_done("t4", da, 60);
    tick();
    chk("t4_done_once", {31'd0, done_1x}, 32'd0);
    chk("t4_idle", {31'd0, busy_1x}, 32'd0);

    // Swap held while busy, cfg toggling every cycle
    do_start(32'd4, 1'b1, 32'd4, 1'b0);
    observe(200, -1, -1, -1, 1'b1, 1'b1, ef, en, da, sbad);
    chk("t5_swap_hold", sbad, 32'd0);
    chk("t5_en_len", en, 32'd4);
    check_done("t5", da, 24);

    // Start coincident with done is accepted and relatches swap
    do_start(32'd50, 1'b0, 32'd0, 1'b0);
    chk("t6_busy", {31'd0, busy_1x}, 32'd1);
    chk("t6_swap_new", {31'd0, swap_iq_1x}, 32'd0);
    void'(sb.pop_back());
    observe(21, -1, -1, -1, 1'b0, 1'b0, ef, en, da, sbad);
    chk("t6_in_run", {31'd0, enable_1x}, 32'd1);
    reset_1x = 1'b1;
    tick();
    chk("t6_rst_enable", {31'd0, enable_1x}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy_1x}, 32'd0);
    chk("t6_rst_wc", word_count_1x, 32'd0);
    reset_1x = 1'b0;
    tick();
    chk("t6_no_done", {31'd0, done_1x}, 32'd0);

    // Fresh start after reset
    do_start(32'd3, 1'b1, 32'd3, 1'b0);
    observe(200, -1, -1, -1, 1'b0, 1'b1, ef, en, da, sbad);
    chk("t7_en_first", ef, 32'd16);
    chk("t7_en_len", en, 32'd3);
    chk("t7_swap_hold", sbad, 32'd0);
    check_done("t7", da, 23);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
